// File: rtl/vpu_fp_exp_seq_pkg.sv
// Shared types and constants for the vector exp sequencer that time-multiplexes
// a single pipelined BF16 exp core across the lanes of a vector operand.
package vpu_fp_exp_seq_pkg;

    localparam int OPERAND_WIDTH = 16;
    localparam int EXP_LANE_CNT  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } exp_seq_state_t;

    typedef logic [$clog2(EXP_LANE_CNT+1)-1:0] exp_vlen_t;

endpackage

// File: rtl/vpu_fp_exp_seq.sv
// Issues vlen lanes, one per cycle, to an external in-order exp core and gathers
// the results. Optional watchdog enabled by defining VPU_FP_EXP_SEQ_TIMEOUT_EN.
module vpu_fp_exp_seq
    import vpu_fp_exp_seq_pkg::*;
#(
    parameter int LANE_CNT      = EXP_LANE_CNT,
    parameter int OPERAND_WIDTH = vpu_fp_exp_seq_pkg::OPERAND_WIDTH,
    parameter int TIMEOUT_CYC   = 64
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start_i,
    input  logic [$clog2(LANE_CNT+1)-1:0]     vlen_i,
    input  logic [LANE_CNT*OPERAND_WIDTH-1:0] op_vec_i,
    output logic                              busy_o,
    output logic                              core_start_o,
    output logic [OPERAND_WIDTH-1:0]          core_op_o,
    input  logic                              core_done_i,
    input  logic [OPERAND_WIDTH-1:0]          core_result_i,
    output logic [LANE_CNT*OPERAND_WIDTH-1:0] result_vec_o,
    output logic                              done_o,
    output logic                              err_o
);

    localparam int W  = OPERAND_WIDTH;
    localparam int IW = $clog2(LANE_CNT+1);
    localparam int LW = $clog2(LANE_CNT);
    localparam logic [IW-1:0] LANE_MAX = IW'(LANE_CNT);

    if ((LANE_CNT < 2) || ((LANE_CNT & (LANE_CNT - 1)) != 0) || (TIMEOUT_CYC < 1)) begin : g_param_check
        $error("vpu_fp_exp_seq: LANE_CNT must be a power of 2 >= 2 and TIMEOUT_CYC >= 1");
    end

    exp_seq_state_t state_q, state_d;
    logic [IW-1:0]  issue_idx_q, issue_idx_d;
    logic [IW-1:0]  wr_idx_q, wr_idx_d;
    logic [IW-1:0]  vlen_q, vlen_d;
    logic [IW-1:0]  vlen_in;
    logic [W-1:0]   op_q [LANE_CNT];
    logic [W-1:0]   op_d [LANE_CNT];
    logic [W-1:0]   res_q [LANE_CNT];
    logic [W-1:0]   res_d [LANE_CNT];
    logic [W-1:0]   op_in [LANE_CNT];
    logic           core_start_q, core_start_d;
    logic [W-1:0]   core_op_q, core_op_d;
    logic           done_q, done_d;

`ifdef VPU_FP_EXP_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC+1);
    localparam logic [TW-1:0] WDOG_LIMIT = TW'(TIMEOUT_CYC);
    logic           err_q, err_d;
    logic [TW-1:0]  wdog_q, wdog_d;
`endif

    for (genvar gi = 0; gi < LANE_CNT; gi++) begin : g_lane
        assign op_in[gi]                = op_vec_i[gi*W +: W];
        assign result_vec_o[gi*W +: W]  = res_q[gi];
    end

    assign vlen_in = (vlen_i > LANE_MAX) ? LANE_MAX : vlen_i;

    always_comb begin
        state_d      = state_q;
        issue_idx_d  = issue_idx_q;
        wr_idx_d     = wr_idx_q;
        vlen_d       = vlen_q;
        op_d         = op_q;
        res_d        = res_q;
        core_start_d = 1'b0;
        core_op_d    = core_op_q;
        done_d       = 1'b0;
`ifdef VPU_FP_EXP_SEQ_TIMEOUT_EN
        err_d        = 1'b0;
        wdog_d       = wdog_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    vlen_d      = vlen_in;
                    op_d        = op_in;
                    wr_idx_d    = '0;
                    issue_idx_d = '0;
                    for (int k = 0; k < LANE_CNT; k++) begin
                        res_d[k] = '0;
                    end
`ifdef VPU_FP_EXP_SEQ_TIMEOUT_EN
                    wdog_d = '0;
`endif
                    if (vlen_in == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        // Lane 0 goes out straight from the input so the first
                        // issue cycle is the one right after acceptance.
                        state_d      = ISSUE;
                        core_start_d = 1'b1;
                        core_op_d    = op_in[0];
                        issue_idx_d  = IW'(1);
                    end
                end
            end
            ISSUE, DRAIN: begin
                if (state_q == ISSUE) begin
                    if (issue_idx_q < vlen_q) begin
                        core_start_d = 1'b1;
                        core_op_d    = op_q[issue_idx_q[LW-1:0]];
                        issue_idx_d  = issue_idx_q + IW'(1);
                    end else begin
                        state_d = DRAIN;
                    end
                end
                if (core_done_i && (wr_idx_q < vlen_q)) begin
                    res_d[wr_idx_q[LW-1:0]] = core_result_i;
                    wr_idx_d = wr_idx_q + IW'(1);
                    if (wr_idx_d == vlen_q) begin
                        state_d      = DONE;
                        core_start_d = 1'b0;
                        done_d       = 1'b1;
                    end
                end
`ifdef VPU_FP_EXP_SEQ_TIMEOUT_EN
                wdog_d = core_done_i ? '0 : wdog_q + TW'(1);
                if ((wdog_d == WDOG_LIMIT) && (state_d != DONE)) begin
                    state_d      = DONE;
                    core_start_d = 1'b0;
                    done_d       = 1'b1;
                    err_d        = 1'b1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            issue_idx_q  <= '0;
            wr_idx_q     <= '0;
            vlen_q       <= '0;
            core_start_q <= 1'b0;
            core_op_q    <= '0;
            done_q       <= 1'b0;
            for (int k = 0; k < LANE_CNT; k++) begin
                op_q[k]  <= '0;
                res_q[k] <= '0;
            end
`ifdef VPU_FP_EXP_SEQ_TIMEOUT_EN
            err_q        <= 1'b0;
            wdog_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            issue_idx_q  <= issue_idx_d;
            wr_idx_q     <= wr_idx_d;
            vlen_q       <= vlen_d;
            core_start_q <= core_start_d;
            core_op_q    <= core_op_d;
            done_q       <= done_d;
            op_q         <= op_d;
            res_q        <= res_d;
`ifdef VPU_FP_EXP_SEQ_TIMEOUT_EN
            err_q        <= err_d;
            wdog_q       <= wdog_d;
`endif
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign core_start_o = core_start_q;
    assign core_op_o    = core_op_q;
    assign done_o       = done_q;
`ifdef VPU_FP_EXP_SEQ_TIMEOUT_EN
    assign err_o        = err_q;
`else
    assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_vpu_fp_exp_seq.sv
// Bench for vpu_fp_exp_seq: external exp core modelled as a variable-latency
// in-order pipeline with a small lookup; expected lanes derived per transaction.
module tb_vpu_fp_exp_seq;

    localparam int LANES = 16;
    localparam int W     = 16;
    localparam int VW    = $clog2(LANES+1);
    localparam int TO    = 64;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start_i = 1'b0;
    logic [VW-1:0]       vlen_i = '0;
    logic [LANES*W-1:0]  op_vec_i = '0;
    logic                busy_o;
    logic                core_start_o;
    logic [W-1:0]        core_op_o;
    logic                core_done_i;
    logic [W-1:0]        core_result_i;
    logic [LANES*W-1:0]  result_vec_o;
    logic                done_o;
    logic                err_o;

    int total = 0;
    int bad   = 0;
    int lat   = 4;
    bit drop  = 1'b0;

    always #5 clk = ~clk;

    vpu_fp_exp_seq #(.LANE_CNT(LANES), .OPERAND_WIDTH(W), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .vlen_i(vlen_i), .op_vec_i(op_vec_i),
        .busy_o(busy_o), .core_start_o(core_start_o), .core_op_o(core_op_o),
        .core_done_i(core_done_i), .core_result_i(core_result_i),
        .result_vec_o(result_vec_o), .done_o(done_o), .err_o(err_o)
    );

    // Core transfer function: exact BF16 exp for the two points the plan uses.
    function automatic logic [W-1:0] fexp(input logic [W-1:0] x);
        if (x == 16'h0000)      return 16'h3F80;
        else if (x == 16'h3F80) return 16'h402E;
        else                    return x * 16'd3 + 16'd7;
    endfunction

    logic [7:0]   pv = '0;
    logic [W-1:0] pd [8];
    always @(posedge clk) begin
        pv    <= {pv[6:0], core_start_o};
        pd[0] <= fexp(core_op_o);
        for (int i = 1; i < 8; i++) pd[i] <= pd[i-1];
    end
    always_comb begin
        core_done_i   = 1'b0;
        core_result_i = '0;
        if (lat == 0) begin
            core_done_i   = core_start_o;
            core_result_i = fexp(core_op_o);
        end else begin
            core_done_i   = pv[lat-1];
            core_result_i = pd[lat-1];
        end
        if (drop) core_done_i = 1'b0;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LANES*W-1:0] rand_vec();
        logic [LANES*W-1:0] v;
        for (int i = 0; i < LANES/2; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic run_vec(input logic [LANES*W-1:0] ops, input int vl, input int lat_in,
                           input bit collide, input bit drop_in);
        int vlc, n, exp_cyc;
        bit got_done, busy_bad, ops_bad;
        logic [W-1:0] issued [$];
        logic [LANES*W-1:0] exp_res;
        lat  = lat_in;
        drop = drop_in;
        vlc  = (vl > LANES) ? LANES : vl;
        exp_res = '0;
        for (int k = 0; k < vlc; k++)
            if (!drop_in) exp_res[k*W +: W] = fexp(ops[k*W +: W]);
        if (vlc == 0)     exp_cyc = 1;
        else if (drop_in) exp_cyc = TO + 1;
        else              exp_cyc = vlc + lat_in + 1;

        @(negedge clk);
        start_i  = 1'b1;
        vlen_i   = vl[VW-1:0];
        op_vec_i = ops;
        @(posedge clk);
        #1;
        start_i  = 1'b0;
        op_vec_i = rand_vec();
        n = 0; got_done = 0; busy_bad = 0;
        while (n < 300 && !got_done) begin
            @(negedge clk);
            n++;
            if (collide && n == 2) begin
                start_i  = 1'b1;
                vlen_i   = VW'(3);
                op_vec_i = ~ops;
            end else begin
                start_i = 1'b0;
            end
            if (core_start_o) issued.push_back(core_op_o);
            if (!busy_o) busy_bad = 1;
            if (done_o) got_done = 1;
        end
        start_i = 1'b0;
        check("done_seen", 256'(got_done), 256'(1));
        check("done_cycle", 256'(n), 256'(exp_cyc));
        check("busy_until_done", 256'(busy_bad), 256'(0));
        check("err_at_done", 256'(err_o), 256'(drop_in));
        check("issue_count", 256'(issued.size()), 256'(vlc));
        ops_bad = 0;
        for (int k = 0; k < issued.size() && k < vlc; k++)
            if (issued[k] !== ops[k*W +: W]) ops_bad = 1;
        check("issue_order", 256'(ops_bad), 256'(0));
        check("result_vec", result_vec_o, exp_res);
        @(negedge clk);
        check("done_pulse_width", 256'({done_o, err_o, busy_o}), 256'(0));
        repeat (2) @(negedge clk);
        check("result_hold", result_vec_o, exp_res);
        $display("txn vlen=%0d lat=%0d collide=%0d drop=%0d cycles=%0d issued=%0d",
                 vl, lat_in, collide, drop_in, n, issued.size());
        drop = 1'b0;
    endtask

    initial begin
        logic [LANES*W-1:0] v;
        int n;
        bit saw_done;

        #1;
        check("reset_outputs", 256'({busy_o, core_start_o, done_o, err_o}), 256'(0));
        check("reset_core_op", 256'(core_op_o), 256'(0));
        check("reset_result", result_vec_o, 256'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single element through an L=4 core.
        run_vec('0, 1, 4, 0, 0);
        // Full vector of 1.0.
        for (int k = 0; k < LANES; k++) v[k*W +: W] = 16'h3F80;
        run_vec(v, 16, 4, 0, 0);
        // Zero length.
        run_vec(rand_vec(), 0, 4, 0, 0);
        // Busy collision.
        run_vec(rand_vec(), 5, 3, 1, 0);
        // Oversized length clamps to LANES.
        run_vec(rand_vec(), 31, 2, 0, 0);
        // Randomized lengths and latencies, including zero-latency core.
        for (int t = 0; t < 8; t++)
            run_vec(rand_vec(), int'($urandom_range(0, 20)), int'($urandom_range(0, 6)), 0, 0);

        // Reset while draining.
        lat = 4;
        @(negedge clk);
        start_i = 1'b1; vlen_i = VW'(8); op_vec_i = rand_vec();
        @(posedge clk);
        #1 start_i = 1'b0;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (busy_o && !core_start_o && n > 1) break;
        end
        check("reached_drain", 256'(n < 50), 256'(1));
        rst_n = 1'b0;
        #1;
        check("midrun_reset_ctrl", 256'({busy_o, core_start_o, done_o, err_o}), 256'(0));
        check("midrun_reset_op", 256'(core_op_o), 256'(0));
        check("midrun_reset_result", result_vec_o, 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 0;
        repeat (8) begin
            @(negedge clk);
            if (done_o || busy_o) saw_done = 1;
        end
        check("late_results_ignored", result_vec_o, 256'(0));
        check("idle_after_reset", 256'(saw_done), 256'(0));
        run_vec(rand_vec(), 2, 4, 0, 0);

`ifdef VPU_FP_EXP_SEQ_TIMEOUT_EN
        run_vec(rand_vec(), 4, 4, 0, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
